// File: rtl/calc_job_sequencer_pkg.sv
// Shared definitions for the calculator command sequencer: widths, FSM
// state encoding and the packed command record stored in the FIFO.
package calc_job_sequencer_pkg;

  localparam int OPND_W = 3;
  localparam int OP_W   = 2;
  localparam int WD_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESULT = 2'd3
  } state_e;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [OPND_W-1:0] in1;
    logic [OPND_W-1:0] in2;
  } cmd_t;

endpackage

// File: rtl/calc_cmd_fifo.sv
// Synchronous command FIFO holding {op,in1,in2}. No bypass: an entry pushed
// into an empty FIFO becomes visible at the head on the following cycle.
module calc_cmd_fifo
  import calc_job_sequencer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  cmd_t                   push_data_i,
  input  logic                   pop_i,
  output cmd_t                   head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW = $clog2(DEPTH);

  cmd_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign level_o = cnt_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (!do_push && do_pop) cnt_q <= cnt_q - 1'b1;
    end
  end

  // Storage array; contents are qualified by the count so it needs no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/calc_job_sequencer.sv
// Issues queued calculator jobs one at a time, waits for done (or a watchdog
// abort) and holds the result on a valid/ready port until it is accepted.
module calc_job_sequencer
  import calc_job_sequencer_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [OP_W-1:0]        cmd_op,
  input  logic [OPND_W-1:0]      cmd_in1,
  input  logic [OPND_W-1:0]      cmd_in2,
  output logic                   go,
  output logic [OP_W-1:0]        op,
  output logic [OPND_W-1:0]      in1,
  output logic [OPND_W-1:0]      in2,
  input  logic                   done,
  input  logic [OPND_W-1:0]      calc_out,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [OPND_W-1:0]      res_data,
  output logic [OP_W-1:0]        res_op,
  output logic                   res_err,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
);

  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic              go_q, go_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [OPND_W-1:0] in1_q, in1_d;
  logic [OPND_W-1:0] in2_q, in2_d;
  logic              res_valid_q, res_valid_d;
  logic [OPND_W-1:0] res_data_q, res_data_d;
  logic [OP_W-1:0]   res_op_q, res_op_d;
  logic              res_err_q, res_err_d;
  logic [WD_W-1:0]   wd_q, wd_d;

  cmd_t cmd_in;
  cmd_t head;
  logic fifo_full;
  logic fifo_empty;
  logic issue;
  logic accept;
  logic wd_expired;

  assign cmd_in     = {cmd_op, cmd_in1, cmd_in2};
  // A done level seen while idle is stale from a previous job and blocks issue.
  assign issue      = (state_q == ST_IDLE) && !fifo_empty && !done;
  assign accept     = res_valid_q && res_ready;
  assign wd_expired = (wd_q == WD_LAST);

  calc_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (cmd_valid),
    .push_data_i (cmd_in),
    .pop_i       (issue),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (level)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (issue) state_d = ST_ISSUE;
      ST_ISSUE:  state_d = ST_WAIT;
      ST_WAIT:   if (done || wd_expired) state_d = ST_RESULT;
      ST_RESULT: if (accept) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and watchdog; done beats the watchdog.
  always_comb begin
    go_d        = 1'b0;
    op_d        = op_q;
    in1_d       = in1_q;
    in2_d       = in2_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_op_d    = res_op_q;
    res_err_d   = res_err_q;
    wd_d        = wd_q;
    unique case (state_q)
      ST_IDLE: begin
        if (issue) begin
          go_d  = 1'b1;
          op_d  = head.op;
          in1_d = head.in1;
          in2_d = head.in2;
        end
      end
      ST_ISSUE: wd_d = '0;
      ST_WAIT: begin
        if (done) begin
          res_valid_d = 1'b1;
          res_data_d  = calc_out;
          res_op_d    = op_q;
          res_err_d   = 1'b0;
        end else if (wd_expired) begin
          res_valid_d = 1'b1;
          res_data_d  = '0;
          res_op_d    = op_q;
          res_err_d   = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      ST_RESULT: if (accept) res_valid_d = 1'b0;
      default: ;
    endcase
  end

  // Output and watchdog registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      go_q        <= 1'b0;
      op_q        <= '0;
      in1_q       <= '0;
      in2_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_op_q    <= '0;
      res_err_q   <= 1'b0;
      wd_q        <= '0;
    end else begin
      go_q        <= go_d;
      op_q        <= op_d;
      in1_q       <= in1_d;
      in2_q       <= in2_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_op_q    <= res_op_d;
      res_err_q   <= res_err_d;
      wd_q        <= wd_d;
    end
  end

  assign cmd_ready = !fifo_full;
  assign go        = go_q;
  assign op        = op_q;
  assign in1       = in1_q;
  assign in2       = in2_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_op    = res_op_q;
  assign res_err   = res_err_q;
  assign busy      = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_calc_job_sequencer.sv
// Bench for calc_job_sequencer: a small calculator model answers go pulses,
// expected results are queued at push time and compared on result handshakes.
module tb_calc_job_sequencer;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  typedef struct packed {
    logic [1:0] op;
    logic [2:0] data;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_in1;
  logic [2:0] cmd_in2;
  logic       go;
  logic [1:0] op;
  logic [2:0] in1;
  logic [2:0] in2;
  logic       done;
  logic [2:0] calc_out;
  logic       res_valid;
  logic       res_ready;
  logic [2:0] res_data;
  logic [1:0] res_op;
  logic       res_err;
  logic       busy;
  logic [2:0] level;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  // Calculator model controls.
  logic       force_done = 1'b0;
  logic       calc_en    = 1'b1;
  int         calc_delay = 3;
  logic       pulse      = 1'b0;
  logic [2:0] mres       = '0;

  assign done     = force_done | pulse;
  assign calc_out = pulse ? mres : 3'd0;

  calc_job_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_in1   (cmd_in1),
    .cmd_in2   (cmd_in2),
    .go        (go),
    .op        (op),
    .in1       (in1),
    .in2       (in2),
    .done      (done),
    .calc_out  (calc_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_op    (res_op),
    .res_err   (res_err),
    .busy      (busy),
    .level     (level)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] calc_f(input logic [1:0] o, input logic [2:0] a, input logic [2:0] b);
    case (o)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a ^ b;
    endcase
  endfunction

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one command and hold it until accepted; records the expected result.
  task automatic push(input logic [1:0] o, input logic [2:0] a, input logic [2:0] b, output int stall);
    exp_t e;
    stall     = 0;
    cmd_valid = 1'b1;
    cmd_op    = o;
    cmd_in1   = a;
    cmd_in2   = b;
    while (!cmd_ready && stall < 200) begin
      step();
      stall++;
    end
    if (!cmd_ready) check("push_timeout", 0, 1);
    step();
    cmd_valid = 1'b0;
    e.op   = o;
    e.data = calc_en ? calc_f(o, a, b) : 3'd0;
    e.err  = !calc_en;
    sb.push_back(e);
  endtask

  task automatic wait_go(input string tag);
    int n = 0;
    while (!go && n < 50) begin
      step();
      n++;
    end
    check(tag, go, 1);
  endtask

  task automatic wait_resv(input string tag);
    int n = 0;
    while (!res_valid && n < 100) begin
      step();
      n++;
    end
    check(tag, res_valid, 1);
  endtask

  task automatic drain(input string tag, input int max);
    int n = 0;
    while (sb.size() != 0 && n < max) begin
      step();
      n++;
    end
    check(tag, sb.size(), 0);
    step();
    step();
  endtask

  // Calculator model: answers each go with a one-cycle done after calc_delay cycles.
  initial begin
    int         cnt = 0;
    logic       pend = 1'b0;
    forever begin
      step();
      pulse = 1'b0;
      if (go && calc_en) begin
        pend = 1'b1;
        cnt  = calc_delay;
        mres = calc_f(op, in1, in2);
      end else if (pend) begin
        cnt--;
        if (cnt <= 0) begin
          pulse = 1'b1;
          pend  = 1'b0;
        end
      end
      if (!busy) pend = 1'b0;
    end
  end

  // Scoreboard: compare on every result handshake, sampled mid-cycle.
  always @(negedge clk) begin
    if (res_valid && res_ready) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("res_data", res_data, e.data);
        check("res_op", res_op, e.op);
        check("res_err", res_err, e.err);
      end
    end
  end

  initial begin
    int stall;
    int gos;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_in1   = '0;
    cmd_in2   = '0;
    res_ready = 1'b1;
    repeat (3) step();
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_level", level, 0);
    check("rst_go", go, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_outs", {op, in1, in2, res_data, res_op, res_err}, 0);
    reset = 1'b0;
    step();

    // Single job: latency, go pulse width, operands held.
    calc_delay = 3;
    push(2'b00, 3'd3, 3'd2, stall);
    check("t1_go_early", go, 0);
    step();
    check("t1_go_t2", go, 1);
    check("t1_in1", in1, 3);
    check("t1_in2", in2, 2);
    step();
    check("t1_go_pulse", go, 0);
    step();
    check("t1_in_held", {in1, in2}, {3'd3, 3'd2});
    step();
    check("t1_resv_early", res_valid, 0);
    step();
    check("t1_resv", res_valid, 1);
    check("t1_res_data", res_data, 5);
    drain("t1_drain", 20);

    // Five commands into a 4-deep FIFO while issue is blocked.
    calc_delay = 2;
    force_done = 1'b1;
    step();
    push(2'd1, 3'd6, 3'd1, stall);
    push(2'd2, 3'd7, 3'd5, stall);
    push(2'd3, 3'd4, 3'd6, stall);
    push(2'd0, 3'd7, 3'd7, stall);
    check("t2_level_full", level, 4);
    check("t2_ready_low", cmd_ready, 0);
    check("t2_no_go", go, 0);
    fork
      push(2'd1, 3'd2, 3'd5, stall);
      begin
        repeat (4) step();
        force_done = 1'b0;
      end
    join
    check("t2_stalled", (stall >= 3) ? 1 : 0, 1);
    drain("t2_drain", 400);

    // Result back-pressure holds everything; next go two cycles after accept.
    res_ready = 1'b0;
    push(2'd1, 3'd6, 3'd2, stall);
    push(2'd3, 3'd5, 3'd1, stall);
    wait_resv("t3_resv");
    repeat (10) begin
      check("t3_hold_valid", res_valid, 1);
      check("t3_hold_data", res_data, calc_f(2'd1, 3'd6, 3'd2));
      check("t3_hold_op", res_op, 1);
      check("t3_hold_go", go, 0);
      check("t3_hold_level", level, 1);
      step();
    end
    res_ready = 1'b1;
    step();
    check("t3_go_k1", go, 0);
    step();
    check("t3_go_k2", go, 1);
    check("t3_in1_next", in1, 5);
    drain("t3_drain", 40);

    // Watchdog abort, then a normal job.
    calc_en = 1'b0;
    push(2'd2, 3'd7, 3'd3, stall);
    wait_go("t4_go");
    repeat (TIMEOUT) step();
    check("t4_resv_early", res_valid, 0);
    step();
    check("t4_resv", res_valid, 1);
    check("t4_err", res_err, 1);
    check("t4_data", res_data, 0);
    drain("t4_drain", 10);
    calc_en = 1'b1;
    push(2'd0, 3'd1, 3'd4, stall);
    drain("t4_next_drain", 40);

    // Reset mid-job with three commands queued.
    calc_en = 1'b0;
    push(2'd0, 3'd1, 3'd1, stall);
    push(2'd1, 3'd2, 3'd2, stall);
    push(2'd2, 3'd3, 3'd3, stall);
    push(2'd3, 3'd4, 3'd4, stall);
    check("t5_level_q", level, 3);
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    sb.delete();
    check("t5_level", level, 0);
    check("t5_ready", cmd_ready, 1);
    check("t5_busy", busy, 0);
    check("t5_outs", {go, op, in1, in2, res_valid, res_data, res_op, res_err}, 0);
    gos = 0;
    repeat (20) begin
      step();
      if (go) gos++;
    end
    check("t5_no_go", gos, 0);
    calc_en = 1'b1;

    // Stale done in IDLE blocks issue until it falls.
    force_done = 1'b1;
    step();
    push(2'd3, 3'd6, 3'd3, stall);
    repeat (5) begin
      step();
      check("t6_no_go", go, 0);
      check("t6_level", level, 1);
    end
    force_done = 1'b0;
    step();
    check("t6_go", go, 1);
    drain("t6_drain", 40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
